// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizing for the pulse train sequencer.
package pulse_seq_pkg;

  localparam int DEF_CNT_W   = 3;
  localparam int DEF_WIDTH_W = 8;
  localparam int DEF_GAP_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } seq_state_t;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module pulse_timer
  import pulse_seq_pkg::*;
#(
  parameter int W = DEF_WIDTH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (!zero) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/pulse_train_sequencer.sv
// Abortable pulse train generator: N pulses of programmable high/low width,
// optionally repeated in bursts separated by a programmable gap.
module pulse_train_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIDTH_W = DEF_WIDTH_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic [WIDTH_W-1:0] cfg_high,
  input  logic [WIDTH_W-1:0] cfg_low,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic               cfg_repeat,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   pulses_sent
);

  localparam int TIMER_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;

  seq_state_t state, state_n;

  logic [CNT_W-1:0]   num_q;
  logic [WIDTH_W-1:0] high_q;
  logic [WIDTH_W-1:0] low_q;
  logic [GAP_W-1:0]   gap_q;
  logic               repeat_q;

  logic               latch_cfg;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;
  logic               done_n;
  logic               aborted_n;
  logic               cfg_err_n;
  logic [CNT_W-1:0]   sent_n;

  // Reload values for the shared timer; zero low/gap widths stretch to one cycle.
  logic [TIMER_W-1:0] start_high_m1;
  logic [TIMER_W-1:0] high_m1;
  logic [TIMER_W-1:0] low_m1;
  logic [TIMER_W-1:0] gap_m1;

  assign start_high_m1 = TIMER_W'(cfg_high - WIDTH_W'(1));
  assign high_m1       = TIMER_W'(high_q - WIDTH_W'(1));
  assign low_m1        = (low_q == '0) ? '0 : TIMER_W'(low_q - WIDTH_W'(1));
  assign gap_m1        = (gap_q == '0) ? '0 : TIMER_W'(gap_q - GAP_W'(1));

  pulse_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .value   (timer_value),
    .zero    (timer_zero)
  );

  always_comb begin
    state_n    = state;
    latch_cfg  = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    cfg_err_n  = 1'b0;
    sent_n     = pulses_sent;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_num == '0 || cfg_high == '0) begin
            cfg_err_n = 1'b1;
          end else begin
            latch_cfg  = 1'b1;
            state_n    = HIGH;
            timer_load = 1'b1;
            timer_val  = start_high_m1;
            sent_n     = CNT_W'(1);
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (timer_zero) begin
          timer_load = 1'b1;
          if (pulses_sent < num_q) begin
            state_n   = LOW;
            timer_val = low_m1;
          end else if (repeat_q) begin
            state_n   = GAP;
            timer_val = gap_m1;
          end else begin
            state_n    = IDLE;
            timer_load = 1'b0;
            done_n     = 1'b1;
          end
        end
      end
      LOW: begin
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (timer_zero) begin
          state_n    = HIGH;
          timer_load = 1'b1;
          timer_val  = high_m1;
          sent_n     = pulses_sent + CNT_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (timer_zero) begin
          state_n    = HIGH;
          timer_load = 1'b1;
          timer_val  = high_m1;
          sent_n     = CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      pulses_sent <= '0;
    end else begin
      state       <= state_n;
      pulse_out   <= (state_n == HIGH);
      busy        <= (state_n != IDLE);
      done        <= done_n;
      aborted     <= aborted_n;
      cfg_err     <= cfg_err_n;
      pulses_sent <= sent_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      gap_q    <= '0;
      repeat_q <= 1'b0;
    end else if (latch_cfg) begin
      num_q    <= cfg_num;
      high_q   <= cfg_high;
      low_q    <= cfg_low;
      gap_q    <= cfg_gap;
      repeat_q <= cfg_repeat;
    end
  end

endmodule
